// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the single register-file write port between the
// non-stallable WB stage and the multi-cycle mul/div unit (MD).
// WB always wins. MD results wait in a small circular queue and drain into
// cycles where WB does not write. A WB write to register r kills any queued
// MD write to r, because the queued result is older than the WB value.
// Optional build macro: RF_ARB_STATS_EN enables the WB-over-MD conflict counter.
module rf_wr_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_we,
    input  logic [AW-1:0]      wb_wa,
    input  logic [DW-1:0]      wb_wd,
    input  logic               md_valid,
    output logic               md_ready,
    input  logic [AW-1:0]      md_wa,
    input  logic [DW-1:0]      md_wd,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd,
    output logic [2**AW-1:0]   pending,
    output logic               busy,
    output logic [15:0]        conflicts
);

    localparam int AIW = $clog2(DEPTH);
    localparam int PW  = AIW + 1;

    // Queue storage. An entry's valid bit is set only while the slot is occupied
    // and not killed, so the valid mask alone describes the live entries.
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [DEPTH-1:0] q_vld;
    logic [AW-1:0]    q_wa [DEPTH];
    logic [DW-1:0]    q_wd [DEPTH];

    logic             empty, full;
    logic             grant_wb, grant_md;
    logic             accept, push;
    logic             hit;
    logic [AIW-1:0]   hit_off;
    logic [AIW-1:0]   hit_idx;
    logic [PW-1:0]    rd_nxt;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AIW-1:0] == rd_ptr[AIW-1:0]) && (wr_ptr[AIW] != rd_ptr[AIW]);

    // Address 0 is hardwired, so a WB write to it is no request at all.
    assign grant_wb = wb_we && (wb_wa != '0);
    assign grant_md = !grant_wb && !empty;

    // A drain cycle always frees at least one slot, so a full queue can still accept.
    assign md_ready = !full || grant_md;
    assign accept   = md_valid && md_ready;
    assign push     = accept && (md_wa != '0);

    // Find the oldest live entry; killed entries ahead of it are skipped for free.
    always_comb begin
        hit     = 1'b0;
        hit_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && q_vld[rd_ptr[AIW-1:0] + AIW'(i)]) begin
                hit     = 1'b1;
                hit_off = AIW'(i);
            end
        end
    end

    assign hit_idx = rd_ptr[AIW-1:0] + hit_off;
    // With no live entry left, the drain discards everything that is queued.
    assign rd_nxt  = hit ? (rd_ptr + PW'(hit_off) + PW'(1)) : wr_ptr;

    // Queue pointers and valid bits: kill, pop, then push (push wins on a shared slot).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_vld  <= '0;
        end else begin
            if (grant_wb) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_wa[i] == wb_wa) q_vld[i] <= 1'b0;
                end
            end
            if (grant_md) begin
                if (hit) q_vld[hit_idx] <= 1'b0;
                rd_ptr <= rd_nxt;
            end
            if (push) begin
                q_vld[wr_ptr[AIW-1:0]] <= 1'b1;
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // Queue payload; needs no reset because the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            q_wa[wr_ptr[AIW-1:0]] <= md_wa;
            q_wd[wr_ptr[AIW-1:0]] <= md_wd;
        end
    end

    // Registered register-file write port; address/data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (grant_wb) begin
            rf_we <= 1'b1;
            rf_wa <= wb_wa;
            rf_wd <= wb_wd;
        end else if (grant_md && hit) begin
            rf_we <= 1'b1;
            rf_wa <= q_wa[hit_idx];
            rf_wd <= q_wd[hit_idx];
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Registers with a queued or issuing write, for the hazard unit.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i]) pending[q_wa[i]] = 1'b1;
        end
        if (rf_we) pending[rf_wa] = 1'b1;
        pending[0] = 1'b0;
    end

    assign busy = !empty || rf_we;

`ifdef RF_ARB_STATS_EN
    logic [15:0] conf_q;

    // Count cycles where WB takes the port while MD work is waiting (saturating).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_q <= '0;
        end else if (grant_wb && !empty && (conf_q != 16'hFFFF)) begin
            conf_q <= conf_q + 16'd1;
        end
    end

    assign conflicts = conf_q;
`else
    assign conflicts = 16'h0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: stimulus queues the expected register
// file writes, a negedge monitor pops and compares every rf_we=1 cycle.
module tb_rf_wr_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

`ifdef RF_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wb_we = 1'b0;
    logic [AW-1:0]     wb_wa = '0;
    logic [DW-1:0]     wb_wd = '0;
    logic              md_valid = 1'b0;
    logic              md_ready;
    logic [AW-1:0]     md_wa = '0;
    logic [DW-1:0]     md_wd = '0;
    logic              rf_we;
    logic [AW-1:0]     rf_wa;
    logic [DW-1:0]     rf_wd;
    logic [2**AW-1:0]  pending;
    logic              busy;
    logic [15:0]       conflicts;

    rf_wr_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .md_valid(md_valid), .md_ready(md_ready), .md_wa(md_wa), .md_wd(md_wd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pending(pending), .busy(busy), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   checks   = 0;
    int   failures = 0;
    logic last_rdy = 1'b0;

    function automatic logic [15:0] cexp(input int n);
        return STATS ? 16'(n) : 16'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; md_ready is sampled before the edge that uses it.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic mv, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd);
        wb_we = we; wb_wa = wa; wb_wd = wd;
        md_valid = mv; md_wa = mwa; md_wd = mwd;
        #2;
        last_rdy = md_ready;
        tick();
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic expect_wr(input int wa, input int wd);
        wr_t e;
        e.wa = AW'(wa);
        e.wd = DW'(wd);
        exp_q.push_back(e);
    endtask

    // Monitor: every RF write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rf_write_unexpected got wa=%0d wd=%0h exp none", rf_wa, rf_wd);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_wa !== mon_e.wa || rf_wd !== mon_e.wd) begin
                    failures++;
                    $display("FAIL rf_write got wa=%0d wd=%0h exp wa=%0d wd=%0h",
                             rf_wa, rf_wd, mon_e.wa, mon_e.wd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_wa", rf_wa, 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_conflicts", conflicts, 0);
        rst = 1'b1;
        #1;
        chk("rst_md_ready", md_ready, 1);

        // Single MD result with WB idle
        expect_wr(5, 'h11);
        cyc(1'b0, '0, '0, 1'b1, AW'(5), 'h11);
        chk("t2_rdy", last_rdy, 1);
        chk("t2_rf_we_q", rf_we, 0);
        chk("t2_pend_q", pending[5], 1);
        chk("t2_busy_q", busy, 1);
        idle();
        chk("t2_pend_issue", pending[5], 1);
        chk("t2_busy_issue", busy, 1);
        idle();
        chk("t2_pend_done", pending, 0);
        chk("t2_busy_done", busy, 0);

        // WB streams r3 for 6 cycles while MD pushes 5 results
        for (int i = 0; i < 6; i++) expect_wr(3, 'h300 + i);
        for (int k = 0; k < 5; k++) expect_wr(10 + k, 'hA0 + k);
        cyc(1'b1, AW'(3), 'h300, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, AW'(3), DW'('h301 + k), 1'b1, AW'(10 + k), DW'('hA0 + k));
            chk("t3_rdy", last_rdy, 1);
        end
        cyc(1'b1, AW'(3), 'h305, 1'b1, AW'(14), 'hA4);
        chk("t3_rdy_full", last_rdy, 0);
        cyc(1'b0, '0, '0, 1'b1, AW'(14), 'hA4);
        chk("t3_rdy_pop", last_rdy, 1);
        repeat (4) idle();
        chk("t3_conflicts", conflicts, cexp(4));
        idle();
        chk("t3_busy_done", busy, 0);

        // Queued r7=AA overwritten by WB r7=BB; same-cycle push is not killed
        expect_wr(7, 'hBB);
        expect_wr(8, 'hB8);
        expect_wr(8, 'hC8);
        cyc(1'b0, '0, '0, 1'b1, AW'(7), 'hAA);
        cyc(1'b1, AW'(7), 'hBB, 1'b0, '0, '0);
        chk("t4_pend_kill", pending, 32'h80);
        idle();
        chk("t4_rf_we_skip", rf_we, 0);
        chk("t4_pend_empty", pending, 0);
        chk("t4_busy_empty", busy, 0);
        cyc(1'b1, AW'(8), 'hB8, 1'b1, AW'(8), 'hC8);
        chk("t4_pend_young", pending, 32'h100);
        idle();
        idle();
        chk("t4_pend_done", pending, 0);
        chk("t4_conflicts", conflicts, cexp(5));

        // Writes to r0 from either source are dropped
        cyc(1'b1, '0, 'h66, 1'b1, '0, 'h55);
        chk("t5_rdy", last_rdy, 1);
        chk("t5_rf_we", rf_we, 0);
        chk("t5_busy", busy, 0);
        cyc(1'b0, '0, '0, 1'b1, '0, 'h77);
        chk("t5_rdy2", last_rdy, 1);
        chk("t5_pend0", pending[0], 0);
        idle();
        chk("t5_rf_we2", rf_we, 0);

        // Full queue with simultaneous pop/push for 2*DEPTH+1 cycles
        for (int i = 0; i < 4; i++) expect_wr(2, 'h200 + i);
        for (int i = 0; i < 4; i++) expect_wr(16 + i, 'h600 + i);
        for (int k = 0; k < 2 * DEPTH + 1; k++) expect_wr(20 + k, 'h700 + k);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, AW'(2), DW'('h200 + i), 1'b1, AW'(16 + i), DW'('h600 + i));
            chk("t6_fill_rdy", last_rdy, 1);
        end
        chk("t6_pend_full", pending, 32'h000F_0004);
        for (int k = 0; k < 2 * DEPTH + 1; k++) begin
            cyc(1'b0, '0, '0, 1'b1, AW'(20 + k), DW'('h700 + k));
            chk("t6_rdy_wrap", last_rdy, 1);
        end
        repeat (4) idle();
        idle();
        chk("t6_busy_done", busy, 0);
        chk("t6_conflicts", conflicts, cexp(8));

        // Reset while draining with 3 entries still queued
        for (int i = 0; i < 4; i++) expect_wr(4, 'h400 + i);
        expect_wr(21, 'h800);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, AW'(4), DW'('h400 + i), 1'b1, AW'(21 + i), DW'('h800 + i));
        idle();
        chk("t1_busy_before", busy, 1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t1_rf_we", rf_we, 0);
        chk("t1_pending", pending, 0);
        chk("t1_busy", busy, 0);
        chk("t1_conflicts", conflicts, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t1_md_ready", md_ready, 1);
        repeat (3) idle();
        chk("t1_rf_we_after", rf_we, 0);
        chk("t1_busy_after", busy, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
